// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Types and constants for the data memory. Both the arbiter and the data
// memory import this package.
//   DMEM_WORDS   : depth of the data memory in 32-bit words
//   DMEM_AW      : word-address width presented to the memory
//   resp_owner_t : which requester, if any, owns the read data returning
//                  from the memory this cycle
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_WORDS = 2048;
    localparam int DMEM_AW    = 11;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P    = 2'd1,
        D    = 2'd2
    } resp_owner_t;

endpackage : dmem_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between the pipeline MEM stage (p_*) and
// a DMA/loader port (d_*). At most one access is issued per cycle. The
// pipeline normally wins. A DMA request that has been refused MAX_DMA_WAIT
// cycles in a row is forced through ahead of the pipeline.
//
// Ports
//   clk                     : single clock, rising edge
//   reset                   : synchronous, active-low
//   p_req/p_we/p_addr/p_wdata : pipeline request (byte address, word access)
//   p_gnt, stall            : pipeline issued this cycle / MEM stage must hold
//   p_rvalid, p_rdata       : pipeline load response, one cycle after grant
//   d_req/d_we/d_addr/d_wdata : DMA request, same meaning as the pipeline
//   d_gnt, d_rvalid, d_rdata  : DMA grant and load response
//   m_en/m_we/m_addr/m_wdata  : memory command, driven by the granted side
//   m_rdata                 : memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MAX_DMA_WAIT = 4,
    parameter int DMEM_WORDS   = dmem_pkg::DMEM_WORDS
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         p_req,
    input  logic                         p_we,
    input  logic [31:0]                  p_addr,
    input  logic [31:0]                  p_wdata,
    output logic                         p_gnt,
    output logic                         p_rvalid,
    output logic [31:0]                  p_rdata,
    output logic                         stall,

    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [31:0]                  d_addr,
    input  logic [31:0]                  d_wdata,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [31:0]                  d_rdata,

    output logic                         m_en,
    output logic                         m_we,
    output logic [dmem_pkg::DMEM_AW-1:0] m_addr,
    output logic [31:0]                  m_wdata,
    input  logic [31:0]                  m_rdata
);

    import dmem_pkg::*;

    localparam int CNT_W = (MAX_DMA_WAIT < 1) ? 1 : $clog2(MAX_DMA_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DMA_WAIT);

    // State
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    resp_owner_t      owner_q, owner_d;
    logic             rd_oor_q, rd_oor_d;   // owned read was out of range

    // Granted-request mux
    logic             force_d;
    logic             any_gnt;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_in_range;
    logic [31:0]      rsp_data;

    // Byte-offset bits never reach the memory because every access is a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_addr[1:0], d_addr[1:0]};

    assign force_d = (wait_cnt_q == CNT_MAX);

    // -------------------------------------------------------------------------
    // Grant selection. Grants are combinational so the access goes out in the
    // request cycle. Holding reset low blocks every grant, which also keeps a
    // read from being recorded as an owned response.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (d_req && (!p_req || force_d)) begin
                d_gnt = 1'b1;
            end else if (p_req) begin
                p_gnt = 1'b1;
            end
        end
    end

    assign any_gnt   = p_gnt | d_gnt;
    assign sel_we    = d_gnt ? d_we    : p_we;
    assign sel_addr  = d_gnt ? d_addr  : p_addr;
    assign sel_wdata = d_gnt ? d_wdata : p_wdata;

    // Word index must lie below DMEM_WORDS; with 2048 words this is exactly
    // addr[31:13] == 0.
    assign sel_in_range = ({2'b00, sel_addr[31:2]} < 32'(DMEM_WORDS));

    // An out-of-range access is still granted but never enables the memory:
    // stores vanish and loads are answered with zero.
    assign m_en    = any_gnt & sel_in_range;
    assign m_we    = m_en & sel_we;
    assign m_addr  = any_gnt ? sel_addr[DMEM_AW+1:2] : '0;
    assign m_wdata = any_gnt ? sel_wdata : '0;

    assign stall   = p_req & ~p_gnt;

    // -------------------------------------------------------------------------
    // Next state: DMA starvation counter and response ownership.
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!d_req || d_gnt) begin
            wait_cnt_d = '0;
        end else if (!force_d) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        owner_d  = NONE;
        rd_oor_d = 1'b0;
        if (p_gnt && !p_we) begin
            owner_d = P;
        end else if (d_gnt && !d_we) begin
            owner_d = D;
        end
        if (any_gnt && !sel_we) begin
            rd_oor_d = !sel_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples its pre-edge value regardless of statement order.
            wait_cnt_q <= '0;
            owner_q    <= NONE;
            rd_oor_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing. Only the owner sees data; the other side reads zero.
    // -------------------------------------------------------------------------
    assign rsp_data = rd_oor_q ? 32'h0 : m_rdata;

    assign p_rvalid = (owner_q == P);
    assign d_rvalid = (owner_q == D);
    assign p_rdata  = p_rvalid ? rsp_data : 32'h0;
    assign d_rdata  = d_rvalid ? rsp_data : 32'h0;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A small memory model answers reads the
// cycle after m_en with a value derived from the word address, and returns a
// junk pattern otherwise, so a response that is not gated shows up.
// Inputs change 1 ns after the rising edge; checks happen 2 ns after it.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    logic        p_gnt, p_rvalid, stall;
    logic [31:0] p_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [10:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(
        .MAX_DMA_WAIT(4),
        .DMEM_WORDS  (2048)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .p_req   (p_req),
        .p_we    (p_we),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_gnt   (p_gnt),
        .p_rvalid(p_rvalid),
        .p_rdata (p_rdata),
        .stall   (stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [10:0] w);
        return 32'hA5A5_0000 | {21'b0, w};
    endfunction

    always @(posedge clk) begin
        m_rdata <= (m_en && !m_we) ? mem_val(m_addr) : 32'hFFFF_FFFF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        p_req   = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
        d_req   = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        m_rdata = 32'h0;

        // ---- Held in reset: nothing issued, stall follows p_req ----------
        tick();
        p_req = 1'b1; p_addr = 32'h10;
        d_req = 1'b1; d_addr = 32'h44;
        #1;
        check("rst_p_gnt", p_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_en",  m_en,  0);
        check("rst_m_we",  m_we,  0);
        check("rst_stall", stall, 1);
        tick();
        check("rst_p_rvalid", p_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_p_rdata",  p_rdata,  0);
        check("rst_d_rdata",  d_rdata,  0);
        p_req = 1'b0; d_req = 1'b0; reset = 1'b1;
        #1;
        check("idle_stall", stall, 0);

        // ---- Pipeline load, DMA idle ---------------------------------------
        tick();
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h10;
        #1;
        check("pld_p_gnt",  p_gnt,  1);
        check("pld_d_gnt",  d_gnt,  0);
        check("pld_m_en",   m_en,   1);
        check("pld_m_we",   m_we,   0);
        check("pld_m_addr", m_addr, 32'h4);
        check("pld_stall",  stall,  0);
        tick();
        p_req = 1'b0;
        #1;
        check("pld_p_rvalid", p_rvalid, 1);
        check("pld_p_rdata",  p_rdata,  32'hA5A5_0004);
        check("pld_d_rvalid", d_rvalid, 0);
        check("pld_d_rdata",  d_rdata,  0);
        tick();
        check("pld_p_rvalid_once", p_rvalid, 0);
        check("pld_p_rdata_zero",  p_rdata,  0);

        // ---- Pipeline store --------------------------------------------------
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h23; p_wdata = 32'h1234_5678;
        #1;
        check("pst_m_en",    m_en,    1);
        check("pst_m_we",    m_we,    1);
        check("pst_m_addr",  m_addr,  32'h8);
        check("pst_m_wdata", m_wdata, 32'h1234_5678);
        tick();
        p_req = 1'b0; p_we = 1'b0;
        #1;
        check("pst_no_rvalid", p_rvalid, 0);

        // ---- Both request for 6 cycles: DMA forced through on cycle 4 ------
        for (int k = 0; k < 6; k++) begin
            tick();
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h40;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
            #1;
            check($sformatf("fair%0d_p_gnt", k), p_gnt, (k != 4));
            check($sformatf("fair%0d_d_gnt", k), d_gnt, (k == 4));
            check($sformatf("fair%0d_stall", k), stall, (k == 4));
            check($sformatf("fair%0d_m_addr", k), m_addr, (k == 4) ? 32'h11 : 32'h10);
            if (k > 0) begin
                check($sformatf("fair%0d_p_rvalid", k), p_rvalid, (k != 5));
                check($sformatf("fair%0d_d_rvalid", k), d_rvalid, (k == 5));
                check($sformatf("fair%0d_p_rdata", k), p_rdata,
                      (k != 5) ? 32'hA5A5_0010 : 32'h0);
                check($sformatf("fair%0d_d_rdata", k), d_rdata,
                      (k == 5) ? 32'hA5A5_0011 : 32'h0);
            end
            if (k == 5) begin
                check("fair_wait_cnt_cleared", dut.wait_cnt_q, 0);
            end
        end
        tick();
        p_req = 1'b0; d_req = 1'b0;
        #1;
        check("fair_tail_p_rvalid", p_rvalid, 1);
        check("fair_tail_p_rdata",  p_rdata,  32'hA5A5_0010);

        // ---- DMA store out of range: granted, memory untouched -------------
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000; d_wdata = 32'hDEAD_BEEF;
        #1;
        check("oorst_d_gnt", d_gnt, 1);
        check("oorst_p_gnt", p_gnt, 0);
        check("oorst_m_en",  m_en,  0);
        check("oorst_m_we",  m_we,  0);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check("oorst_d_rvalid", d_rvalid, 0);
        check("oorst_d_rdata",  d_rdata,  0);

        // ---- Pipeline load out of range: zero data with rvalid -------------
        tick();
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h2000;
        #1;
        check("oorld_p_gnt", p_gnt, 1);
        check("oorld_m_en",  m_en,  0);
        tick();
        p_req = 1'b0;
        #1;
        check("oorld_p_rvalid", p_rvalid, 1);
        check("oorld_p_rdata",  p_rdata,  0);

        // ---- Alternating back-to-back loads --------------------------------
        tick();
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h4;
        #1;
        check("alt0_p_gnt", p_gnt, 1);
        tick();
        p_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        #1;
        check("alt1_d_gnt",    d_gnt,    1);
        check("alt1_m_addr",   m_addr,   32'h2);
        check("alt1_p_rvalid", p_rvalid, 1);
        check("alt1_p_rdata",  p_rdata,  32'hA5A5_0001);
        check("alt1_d_rvalid", d_rvalid, 0);
        tick();
        d_req = 1'b0;
        #1;
        check("alt2_d_rvalid", d_rvalid, 1);
        check("alt2_d_rdata",  d_rdata,  32'hA5A5_0002);
        check("alt2_p_rvalid", p_rvalid, 0);
        check("alt2_p_rdata",  p_rdata,  0);

        // ---- Read granted, then reset falls before the edge: dropped -------
        tick();
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h4;
        #1;
        check("rdrop_p_gnt_before", p_gnt, 1);
        reset = 1'b0;
        #1;
        check("rdrop_p_gnt_in_rst", p_gnt, 0);
        check("rdrop_m_en_in_rst",  m_en,  0);
        tick();
        #1;
        check("rdrop_p_rvalid", p_rvalid, 0);
        check("rdrop_p_rdata",  p_rdata,  0);
        check("rdrop_d_rvalid", d_rvalid, 0);
        check("rdrop_d_rdata",  d_rdata,  0);
        check("rdrop_p_gnt",    p_gnt,    0);
        check("rdrop_d_gnt",    d_gnt,    0);
        check("rdrop_m_en",     m_en,     0);
        check("rdrop_m_we",     m_we,     0);
        check("rdrop_stall",    stall,    1);

        reset = 1'b1; p_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DMA_WAIT, default 4, meaning max consecutive cycles a pending DMA request is refused before it is forced through.
REQ-002 SHALL have parameter DMEM_WORDS, default 2048, meaning data memory depth in 32-bit words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low.
REQ-005 p_req  in  1  pipeline MEM-stage access request.
REQ-006 p_we  in  1  pipeline write enable (1=store, 0=load).
REQ-007 p_addr  in  32  pipeline byte address.
REQ-008 p_wdata  in  32  pipeline store data.
REQ-009 p_gnt  out  1  pipeline access issued this cycle.
REQ-010 p_rvalid  out  1  pipeline load data valid.
REQ-011 p_rdata  out  32  pipeline load data.
REQ-012 stall  out  1  pipeline MEM stage must hold (p_req & ~p_gnt).
REQ-013 d_req, d_we, d_addr[31:0], d_wdata[31:0]  in  DMA/loader request, same meaning as pipeline.
REQ-014 d_gnt, d_rvalid  out  1; d_rdata  out  32  DMA grant/response, same meaning as pipeline.
REQ-015 m_en, m_we  out  1  memory enable/write enable; m_addr  out  11  word address; m_wdata  out  32.
REQ-016 m_rdata  in  32  memory read data, valid the cycle after a read with m_en=1.

Function
REQ-017 SHALL issue at most one memory access per cycle; p_gnt and d_gnt never both 1.
REQ-018 Grants SHALL be combinational in the request cycle; m_en/m_we/m_addr/m_wdata SHALL be driven combinationally from the granted requester, else m_en=0, m_we=0.
REQ-019 Priority: pipeline wins when both request, unless wait_cnt==MAX_DMA_WAIT, then DMA wins.
REQ-020 wait_cnt SHALL increment each cycle d_req & ~d_gnt, saturate at MAX_DMA_WAIT, clear on d_gnt or ~d_req.
REQ-021 m_addr SHALL be addr[12:2]; addr[1:0] ignored (word access).
REQ-022 Out-of-range (addr[31:13]!=0): grant still given, m_en=0; a load SHALL return rdata=0 with rvalid; a store is dropped.
REQ-023 Response owner register {NONE,P,D} SHALL capture the granted read each cycle; next cycle assert matching rvalid for exactly one cycle, rdata=m_rdata (or 0 if out-of-range).
REQ-024 Writes SHALL produce no rvalid.
REQ-025 rdata of the non-owning requester SHALL be 0 when its rvalid=0.
REQ-026 Back-to-back reads from alternating requesters SHALL each get a response one cycle after grant with no bubble.
REQ-027 Requesters SHALL hold req/we/addr/wdata stable while not granted; arbiter behaviour on violation undefined.

Reset
REQ-028 On reset=0 at a clock edge: wait_cnt=0, response owner=NONE; the following cycle p_rvalid=d_rvalid=0, p_rdata=d_rdata=0.
REQ-029 A read granted in the cycle reset is asserted SHALL produce no rvalid (dropped).
REQ-030 While reset=0, p_gnt=d_gnt=0, m_en=m_we=0, stall=p_req.

Structure
REQ-031 Package dmem_pkg SHALL hold DMEM_WORDS, DMEM_AW=11, and typedef resp_owner_t {NONE,P,D}; shared with DMem.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 p_req read addr 0x10, d idle -> p_gnt=1, m_addr=4, m_en=1; next cycle p_rvalid=1, p_rdata=m_rdata.
REQ-034 p_req and d_req held 6 cycles, MAX_DMA_WAIT=4 -> p_gnt cycles 0-3, d_gnt cycle 4, stall=1 cycle 4, wait_cnt=0 after.
REQ-035 d_we=1 addr 0x8000 data 0xDEADBEEF -> d_gnt=1, m_en=0, no d_rvalid.
REQ-036 p read addr 0x4 cycle 0, d read addr 0x8 cycle 1 -> p_rvalid cycle 1, d_rvalid cycle 2, no overlap.
REQ-037 p read granted, reset=0 same edge -> no p_rvalid next cycle; all outputs 0 except stall=p_req.
